alu_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the bitwise ALU sub-units and drives the ALU result mux. It shares the ALU operand buses (rs1/rs2 values), takes funct3 as its operation code, and computes one bit per cycle. The result is available a fixed XLEN+1 edges after start. The datapath issue logic stalls on o_busy and captures o_result on o_done.

---
 rtl/alu_muldiv.sv | 136 +++++++++++++
 tb/tb_alu_muldiv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, fixed latency of XLEN+1 edges.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            neg_a, neg_b, div0;
    logic [XLEN-1:0] hi, lo, dvs;

    // Operand conditioning at start
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        signed_a = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                   (i_op == OP_DIV) || (i_op == OP_REM);
        signed_b = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                   (i_op == OP_DIV) || (i_op == OP_REM);
        sa    = signed_a & i_opa[XLEN-1];
        sb    = signed_b & i_opb[XLEN-1];
        mag_a = sa ? -i_opa : i_opa;
        mag_b = sb ? -i_opb : i_opb;
    end

    // One iteration of each algorithm; {hi,lo} is the shared working register
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_ge   = div_sh >= {1'b0, dvs};
        div_diff = div_sh[XLEN-1:0] - dvs;
    end

    // Sign correction and field select. A zero divisor leaves an all-ones
    // quotient and |a| as remainder, so only the quotient negation is bypassed.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod_s = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        quo    = ((neg_a ^ neg_b) && !div0) ? -lo : lo;
        rem    = neg_a ? -hi : hi;
        if (op[2])
            fix_res = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            fix_res = prod_s[XLEN-1:0];
        else
            fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            dvs      <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    op    <= i_op;
                    neg_a <= sa;
                    neg_b <= sb;
                    div0  <= (i_opb == '0);
                    hi    <= '0;
                    lo    <= mag_a;
                    dvs   <= mag_b;
                    cnt   <= CW'(XLEN);
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op[2]) begin
                        hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                FIX: o_result <= fix_res;
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected result and completion cycle are
// queued at each accepted start and checked when o_done fires.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] res;

    alu_muldiv #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_opa(a), .i_opb(b), .o_busy(busy), .o_done(done), .o_result(res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0, n_done = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xs, xu, ys, yu, p;
        logic signed [31:0] sx, sy, t;
        xs = {{32{x[31]}}, x}; xu = {32'b0, x};
        ys = {{32{y[31]}}, y}; yu = {32'b0, y};
        sx = x; sy = y;
        p = '0; t = '0;
        case (o)
            3'd0: begin p = xu * yu; return p[31:0]; end
            3'd1: begin p = xs * ys; return p[63:32]; end
            3'd2: begin p = xs * yu; return p[63:32]; end
            3'd3: begin p = xu * yu; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                t = sx / sy; return t;
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                t = sx % sy; return t;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Completion monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.tag, res, e.res);
                chk({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic accept(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        e.tag = tag; e.res = model(o, x, y); e.cyc = cyc + 33;
        sb.push_back(e);
    endtask

    // Runs one op; poke>0 re-pulses i_start with other operands that many cycles in
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        int bcnt = 0;
        accept(tag, o, x, y);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = (poke != 0 && i == poke);
            if (start) begin op = 3'd3; a = ~x; b = y + 32'd5; end
            else begin a = $urandom; b = $urandom; end
            if (busy) bcnt++;
            else break;
        end
        chk({tag, "_busy_cycles"}, bcnt, 34);
        chk({tag, "_drained"}, sb.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", res, 0);
        @(negedge clk); rst = 1'b0;

        run_op("mul_7_m3",       3'd0, 32'd7, 32'hFFFFFFFD, 0);
        run_op("mulh_min_min",   3'd1, 32'h80000000, 32'h80000000, 0);
        run_op("mulhu_ones",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mulhsu_ones",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("div_m7_2",       3'd4, 32'hFFFFFFF9, 32'd2, 0);
        run_op("rem_m7_2",       3'd6, 32'hFFFFFFF9, 32'd2, 0);
        run_op("divu_100_7",     3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7",     3'd7, 32'd100, 32'd7, 0);
        run_op("div_7_m2",       3'd4, 32'd7, 32'hFFFFFFFE, 0);
        run_op("rem_7_m2",       3'd6, 32'd7, 32'hFFFFFFFE, 0);
        run_op("div_5_0",        3'd4, 32'd5, 32'd0, 0);
        run_op("div_m5_0",       3'd4, 32'hFFFFFFFB, 32'd0, 0);
        run_op("rem_m5_0",       3'd6, 32'hFFFFFFFB, 32'd0, 0);
        run_op("divu_5_0",       3'd5, 32'd5, 32'd0, 0);
        run_op("div_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("rem_ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("mul_ignore_2nd", 3'd0, 32'd3, 32'd4, 5);

        // Abort a divide with reset
        accept("div_abort", 3'd4, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", res, 0);
        sb.delete();
        seen = n_done;
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done - seen, 0);

        run_op("mulhu_after_rst", 3'd3, 32'h12345678, 32'h9ABCDEF0, 0);

        // Back-to-back with i_start held; accepts predicted every 35 edges
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            exp_t e;
            op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            @(posedge clk); #1;
            e.tag = "b2b"; e.res = model(op, a, b); e.cyc = cyc + 33;
            sb.push_back(e);
            for (int j = 0; j < 34; j++) begin
                @(negedge clk);
                if (k == 999) start = 1'b0;
                op = 3'($urandom); a = $urandom; b = $urandom;
            end
            if (k < 999) @(negedge clk);
        end
        @(negedge clk);
        chk("b2b_idle", busy, 0);
        chk("b2b_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
